// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM: sequences DP/LDR/STR/B through a Moore state machine
// and drives the datapath strobes, with mem_ready wait states on fetch and data access.
module multicycle_ctrl_fsm #(
    parameter int ALU_CTRL_W = 3,
    parameter int EXT_OPS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            rd,
    input  logic                  mem_ready,
    output logic [3:0]            state,
    output logic                  ir_write,
    output logic                  next_pc,
    output logic                  adr_src,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [1:0]            flag_w,
    output logic                  reg_w,
    output logic                  mem_w,
    output logic                  branch,
    output logic                  pcs,
    output logic                  illegal,
    output logic                  instr_done
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_TRAP   = 4'd10;

    logic [3:0]            state_reg;
    logic [3:0]            state_next;
    logic [2:0]            alu_code;
    logic [ALU_CTRL_W-1:0] alu_ext;
    logic                  dp_legal;
    logic                  is_cmp_tst;
    logic                  is_arith;
    logic [1:0]            op_imm_src;
    logic [1:0]            op_reg_src;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    assign state = state_reg;

    // DP operation decode on funct[4:1]; extended ops are illegal when disabled.
    always_comb begin
        alu_code   = 3'd0;
        dp_legal   = 1'b1;
        is_cmp_tst = 1'b0;
        is_arith   = 1'b0;
        case (funct[4:1])
            4'b0100: begin alu_code = 3'd0; is_arith = 1'b1; end
            4'b0010: begin alu_code = 3'd1; is_arith = 1'b1; end
            4'b0000: alu_code = 3'd2;
            4'b1100: alu_code = 3'd3;
            4'b0001: begin
                if (EXT_OPS != 0) alu_code = 3'd4;
                else              dp_legal = 1'b0;
            end
            4'b1010: begin
                if (EXT_OPS != 0) begin
                    alu_code   = 3'd1;
                    is_cmp_tst = 1'b1;
                    is_arith   = 1'b1;
                end else begin
                    dp_legal = 1'b0;
                end
            end
            4'b1000: begin
                if (EXT_OPS != 0) begin
                    alu_code   = 3'd2;
                    is_cmp_tst = 1'b1;
                end else begin
                    dp_legal = 1'b0;
                end
            end
            default: dp_legal = 1'b0;
        endcase
        alu_ext      = '0;
        alu_ext[2:0] = alu_code;
    end

    always_comb begin
        op_imm_src = 2'b00;
        op_reg_src = 2'b00;
        case (op)
            2'b01: begin
                op_imm_src = 2'b01;
                op_reg_src = funct[0] ? 2'b00 : 2'b10;
            end
            2'b10: begin
                op_imm_src = 2'b10;
                op_reg_src = 2'b01;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    2'b00: begin
                        if (!dp_legal)     state_next = S_TRAP;
                        else if (funct[5]) state_next = S_EXECI;
                        else               state_next = S_EXECR;
                    end
                    2'b01:   state_next = S_MEMADR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_TRAP;
                endcase
            end
            S_MEMADR: state_next = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR,
            S_EXECI:  state_next = is_cmp_tst ? S_FETCH : S_ALUWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        ir_write    = 1'b0;
        next_pc     = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        imm_src     = 2'b00;
        reg_src     = 2'b00;
        alu_control = '0;
        flag_w      = 2'b00;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        branch      = 1'b0;
        illegal     = 1'b0;
        instr_done  = 1'b0;
        // Immediate/register-source selects only matter while an instruction is in flight.
        if (state_reg >= S_DECODE && state_reg <= S_BRANCH) begin
            imm_src = op_imm_src;
            reg_src = op_reg_src;
        end
        case (state_reg)
            S_FETCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready & reset;
                next_pc    = mem_ready & reset;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: alu_src_b = 2'b01;
            S_MEMRD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                adr_src    = 1'b1;
                mem_w      = 1'b1;
                instr_done = mem_ready;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (state_reg == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = alu_ext;
                flag_w      = {funct[0] | is_cmp_tst, funct[0] & is_arith};
                instr_done  = is_cmp_tst;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
        pcs = ((rd == 4'd15) & reg_w) | branch;
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-cycle vector table on two instances
// (extended ops on and off) plus hand-written reset and wait-state sequences.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       mr;

    logic [3:0] a_state, b_state;
    logic       a_ir_write, a_next_pc, a_adr_src, a_alu_src_a;
    logic       b_ir_write, b_next_pc, b_adr_src, b_alu_src_a;
    logic [1:0] a_alu_src_b, a_result_src, a_imm_src, a_reg_src, a_flag_w;
    logic [1:0] b_alu_src_b, b_result_src, b_imm_src, b_reg_src, b_flag_w;
    logic [2:0] a_alu_control, b_alu_control;
    logic       a_reg_w, a_mem_w, a_branch, a_pcs, a_illegal, a_instr_done;
    logic       b_reg_w, b_mem_w, b_branch, b_pcs, b_illegal, b_instr_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.ALU_CTRL_W(3), .EXT_OPS(1)) dut_a (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .mem_ready(mr),
        .state(a_state), .ir_write(a_ir_write), .next_pc(a_next_pc), .adr_src(a_adr_src),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .result_src(a_result_src),
        .imm_src(a_imm_src), .reg_src(a_reg_src), .alu_control(a_alu_control),
        .flag_w(a_flag_w), .reg_w(a_reg_w), .mem_w(a_mem_w), .branch(a_branch),
        .pcs(a_pcs), .illegal(a_illegal), .instr_done(a_instr_done)
    );

    multicycle_ctrl_fsm #(.ALU_CTRL_W(3), .EXT_OPS(0)) dut_b (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .mem_ready(mr),
        .state(b_state), .ir_write(b_ir_write), .next_pc(b_next_pc), .adr_src(b_adr_src),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .result_src(b_result_src),
        .imm_src(b_imm_src), .reg_src(b_reg_src), .alu_control(b_alu_control),
        .flag_w(b_flag_w), .reg_w(b_reg_w), .mem_w(b_mem_w), .branch(b_branch),
        .pcs(b_pcs), .illegal(b_illegal), .instr_done(b_instr_done)
    );

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rd;
        logic        mr;
        logic [26:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Packed order: state, ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
    // imm_src, reg_src, alu_control, flag_w, reg_w, mem_w, branch, pcs, illegal, instr_done
    function automatic logic [26:0] ev(input int st, input int irw, input int npc, input int adr,
                                       input int asa, input int asb, input int rs, input int imm,
                                       input int rsrc, input int alu, input int fw, input int rw,
                                       input int mw, input int br, input int pc, input int ill,
                                       input int done);
        return {st[3:0], irw[0], npc[0], adr[0], asa[0], asb[1:0], rs[1:0], imm[1:0], rsrc[1:0],
                alu[2:0], fw[1:0], rw[0], mw[0], br[0], pc[0], ill[0], done[0]};
    endfunction

    function automatic logic [26:0] pack_a();
        return {a_state, a_ir_write, a_next_pc, a_adr_src, a_alu_src_a, a_alu_src_b, a_result_src,
                a_imm_src, a_reg_src, a_alu_control, a_flag_w, a_reg_w, a_mem_w, a_branch, a_pcs,
                a_illegal, a_instr_done};
    endfunction

    function automatic logic [26:0] pack_b();
        return {b_state, b_ir_write, b_next_pc, b_adr_src, b_alu_src_a, b_alu_src_b, b_result_src,
                b_imm_src, b_reg_src, b_alu_control, b_flag_w, b_reg_w, b_mem_w, b_branch, b_pcs,
                b_illegal, b_instr_done};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
        end
    endtask

    task automatic addv(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                        input logic m, input logic [26:0] e);
        vec_t v;
        v.op = o; v.funct = f; v.rd = r; v.mr = m; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [26:0] rst_vec;

    initial begin
        rst_vec = ev(0, 0,0,0,1,2,2,0,0,0,0, 0,0,0,0,0,0);
        reset = 1'b0; op = 2'b10; funct = 6'd0; rd = 4'd0; mr = 1'b1;
        #2;
        chk("reset_a", {5'd0, pack_a()}, {5'd0, rst_vec});
        chk("reset_b", {5'd0, pack_b()}, {5'd0, rst_vec});
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // ADD R1,R2,#5
        addv(2'b00, 6'b101000, 4'd1, 1'b1, ev(0, 1,1,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b00, 6'b101000, 4'd1, 1'b1, ev(1, 0,0,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b00, 6'b101000, 4'd1, 1'b1, ev(7, 0,0,0,0,1,0,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b00, 6'b101000, 4'd1, 1'b1, ev(8, 0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        // LDR with one parked fetch and three wait cycles in MEMRD
        addv(2'b01, 6'b011001, 4'd3, 1'b0, ev(0, 0,0,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b01, 6'b011001, 4'd3, 1'b1, ev(0, 1,1,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b01, 6'b011001, 4'd3, 1'b1, ev(1, 0,0,0,1,2,2,1,0,0,0, 0,0,0,0,0,0));
        addv(2'b01, 6'b011001, 4'd3, 1'b1, ev(2, 0,0,0,0,1,0,1,0,0,0, 0,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            addv(2'b01, 6'b011001, 4'd3, 1'b0, ev(3, 0,0,1,0,0,0,1,0,0,0, 0,0,0,0,0,0));
        addv(2'b01, 6'b011001, 4'd3, 1'b1, ev(3, 0,0,1,0,0,0,1,0,0,0, 0,0,0,0,0,0));
        addv(2'b01, 6'b011001, 4'd3, 1'b1, ev(4, 0,0,0,0,0,1,1,0,0,0, 1,0,0,0,0,1));
        // STR with two wait cycles in MEMWR
        addv(2'b01, 6'b011000, 4'd4, 1'b1, ev(0, 1,1,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b01, 6'b011000, 4'd4, 1'b1, ev(1, 0,0,0,1,2,2,1,2,0,0, 0,0,0,0,0,0));
        addv(2'b01, 6'b011000, 4'd4, 1'b1, ev(2, 0,0,0,0,1,0,1,2,0,0, 0,0,0,0,0,0));
        addv(2'b01, 6'b011000, 4'd4, 1'b0, ev(5, 0,0,1,0,0,0,1,2,0,0, 0,1,0,0,0,0));
        addv(2'b01, 6'b011000, 4'd4, 1'b0, ev(5, 0,0,1,0,0,0,1,2,0,0, 0,1,0,0,0,0));
        addv(2'b01, 6'b011000, 4'd4, 1'b1, ev(5, 0,0,1,0,0,0,1,2,0,0, 0,1,0,0,0,1));
        // SUBS R2,Rn,Rm
        addv(2'b00, 6'b000101, 4'd2, 1'b1, ev(0, 1,1,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b00, 6'b000101, 4'd2, 1'b1, ev(1, 0,0,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b00, 6'b000101, 4'd2, 1'b1, ev(6, 0,0,0,0,0,0,0,0,1,3, 0,0,0,0,0,0));
        addv(2'b00, 6'b000101, 4'd2, 1'b1, ev(8, 0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        // ANDS R5,Rn,#imm: NZ only
        addv(2'b00, 6'b100001, 4'd5, 1'b1, ev(0, 1,1,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b00, 6'b100001, 4'd5, 1'b1, ev(1, 0,0,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b00, 6'b100001, 4'd5, 1'b1, ev(7, 0,0,0,0,1,0,0,0,2,2, 0,0,0,0,0,0));
        addv(2'b00, 6'b100001, 4'd5, 1'b1, ev(8, 0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,1));
        // ADDS PC,Rn,Rm
        addv(2'b00, 6'b001001, 4'd15, 1'b1, ev(0, 1,1,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b00, 6'b001001, 4'd15, 1'b1, ev(1, 0,0,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b00, 6'b001001, 4'd15, 1'b1, ev(6, 0,0,0,0,0,0,0,0,0,3, 0,0,0,0,0,0));
        addv(2'b00, 6'b001001, 4'd15, 1'b1, ev(8, 0,0,0,0,0,0,0,0,0,0, 1,0,0,1,0,1));
        // B
        addv(2'b10, 6'b100000, 4'd0, 1'b1, ev(0, 1,1,0,1,2,2,0,0,0,0, 0,0,0,0,0,0));
        addv(2'b10, 6'b100000, 4'd0, 1'b1, ev(1, 0,0,0,1,2,2,2,1,0,0, 0,0,0,0,0,0));
        addv(2'b10, 6'b100000, 4'd0, 1'b1, ev(9, 0,0,0,0,1,2,2,1,0,0, 0,0,1,1,0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            op = vecs[i].op; funct = vecs[i].funct; rd = vecs[i].rd; mr = vecs[i].mr;
            @(negedge clk);
            $display("vec %0d op=%b funct=%b rd=%0d mr=%b state=%0d", i, op, funct, rd, mr, a_state);
            chk($sformatf("vec%0d_a", i), {5'd0, pack_a()}, {5'd0, vecs[i].exp});
            chk($sformatf("vec%0d_b", i), {5'd0, pack_b()}, {5'd0, vecs[i].exp});
            @(posedge clk);
            #1;
        end

        // CMP: flags only on the extended instance, trap on the restricted one
        op = 2'b00; funct = 6'b010101; rd = 4'd0; mr = 1'b1;
        step(); step();
        $display("seq cmp state_a=%0d state_b=%0d", a_state, b_state);
        chk("cmp_state", a_state, 6);
        chk("cmp_alu", a_alu_control, 1);
        chk("cmp_flag_w", a_flag_w, 3);
        chk("cmp_done", a_instr_done, 1);
        chk("cmp_reg_w", a_reg_w, 0);
        chk("cmp_trap_state", b_state, 10);
        chk("cmp_trap_illegal", b_illegal, 1);
        chk("cmp_trap_done", b_instr_done, 0);
        step();
        chk("cmp_after_a", a_state, 0);
        chk("cmp_after_b", b_state, 0);
        chk("cmp_illegal_pulse", b_illegal, 0);

        // TST with S=0 still writes NZ
        funct = 6'b010000;
        step(); step();
        $display("seq tst state_a=%0d state_b=%0d", a_state, b_state);
        chk("tst_state", a_state, 6);
        chk("tst_flag_w", a_flag_w, 2);
        chk("tst_alu", a_alu_control, 2);
        chk("tst_done", a_instr_done, 1);
        chk("tst_trap_b", b_state, 10);
        step();
        chk("tst_after", a_state, 0);

        // Undefined DP code, then op=11
        funct = 6'b011110;
        step(); step();
        $display("seq bad_dp state_a=%0d", a_state);
        chk("bad_dp_state", a_state, 10);
        chk("bad_dp_illegal", a_illegal, 1);
        chk("bad_dp_regw_memw", {a_reg_w, a_mem_w, a_instr_done}, 0);
        step();
        chk("bad_dp_after", {a_state, a_illegal}, 0);
        op = 2'b11; funct = 6'b000000;
        step(); step();
        $display("seq op11 state_a=%0d", a_state);
        chk("op11_state", a_state, 10);
        step();
        chk("op11_after", a_state, 0);

        // EOR immediate
        op = 2'b00; funct = 6'b100010; rd = 4'd6;
        step(); step();
        $display("seq eor state_a=%0d state_b=%0d", a_state, b_state);
        chk("eor_state", a_state, 7);
        chk("eor_alu", a_alu_control, 4);
        chk("eor_flag_w", a_flag_w, 0);
        chk("eor_trap_b", b_state, 10);
        step();
        chk("eor_aluwb", a_state, 8);

        // Async reset with mem_ready high: ir_write must stay low
        reset = 1'b0;
        #1;
        chk("rst_async_a", {5'd0, pack_a()}, {5'd0, rst_vec});
        reset = 1'b1;

        // Reset asserted mid-MEMRD, then released with mem_ready=1
        op = 2'b01; funct = 6'b011001; rd = 4'd3; mr = 1'b1;
        step();
        step();
        mr = 1'b0;
        step();
        $display("seq ldr_reset state_a=%0d", a_state);
        chk("memrd_reached", a_state, 3);
        mr = 1'b1;
        #3 reset = 1'b0;
        #1;
        chk("memrd_reset_a", {5'd0, pack_a()}, {5'd0, rst_vec});
        chk("memrd_reset_b", {5'd0, pack_b()}, {5'd0, rst_vec});
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_state", a_state, 0);
        chk("post_reset_ir_write", {a_ir_write, a_next_pc, b_ir_write}, 3'b111);
        step();
        chk("post_reset_decode", a_state, 1);
        step(); step(); step();
        chk("ldr_memwb_state", a_state, 4);
        chk("ldr_memwb_ctl", {a_result_src, a_reg_w}, 3'b011);
        step();
        chk("ldr_back_fetch", a_state, 0);

        // Reset mid-MEMWR drops mem_w at once
        funct = 6'b011000; rd = 4'd4;
        step(); step();
        mr = 1'b0;
        step();
        $display("seq str_reset state_a=%0d mem_w=%b", a_state, a_mem_w);
        chk("memwr_mem_w", {a_state, a_mem_w}, {4'd5, 1'b1});
        #3 reset = 1'b0;
        #1;
        chk("memwr_reset_mem_w", {a_mem_w, b_mem_w}, 0);
        chk("memwr_reset_state", a_state, 0);
        step();
        reset = 1'b1;

        // mem_ready low parks the FSM in FETCH
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("park%0d", k), {a_state, a_ir_write}, 0);
        end
        mr = 1'b1;
        begin
            int n;
            n = 0;
            while (n < 20 && !a_instr_done) begin
                step();
                n++;
            end
            $display("seq str_finish cycles=%0d", n);
            chk("str_done_seen", a_instr_done, 1);
            chk("str_cycles", n, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multicycle successor to the single-cycle main/ALU decoder.
- Sequences each instruction (DP reg/imm, LDR, STR, B) through a Moore state machine and drives the datapath control strobes.
- Supports wait-stated memory through a `mem_ready` handshake and an extended DP operation set.
- Sits in the ControlUnit beside the condition unit, which gates `reg_w`, `mem_w` and `pcs` with `CondEx`.

Parameters:
ALU_CTRL_W, 3, width of `alu_control`; must be >= 3.
EXT_OPS, 1, 1 enables EOR/CMP/TST decode; 0 restricts to ADD/SUB/AND/ORR, others illegal.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
op  in  2  Instr[27:26]
funct  in  6  Instr[25:20]
rd  in  4  Instr[15:12]
mem_ready  in  1  memory completes current access this cycle
state  out  4  current state encoding (debug/verification)
ir_write  out  1  latch instruction register
next_pc  out  1  PC <- PC+4
adr_src  out  1  0 = PC, 1 = ALU result
alu_src_a  out  1  0 = RD1, 1 = PC
alu_src_b  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
imm_src  out  2  00 DP imm8, 01 mem imm12, 10 branch imm24
reg_src  out  2  as in the single-cycle decoder: DP 00, STR 10, B 01
alu_control  out  ALU_CTRL_W  ALU operation
flag_w  out  2  [1] NZ write, [0] CV write
reg_w  out  1  register file write
mem_w  out  1  memory write
branch  out  1  branch PC write
pcs  out  1  (`rd`==15 & `reg_w`) | `branch`
illegal  out  1  one-cycle pulse on unimplemented encoding
instr_done  out  1  one-cycle pulse on final state of each instruction

Behaviour:
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, TRAP 10
  - 11-15 unreachable; they go to FETCH.
- Reset (`reset`=0, async): state=FETCH and all outputs 0, except `alu_src_a`=1, `alu_src_b`=10, `result_src`=10.
- First FETCH after reset release fetches at the current PC.
- Outputs are Moore, decoded from state. Exceptions:
  - `ir_write`, `next_pc` and `mem_w` are qualified by `mem_ready` as stated below.
  - `imm_src`, `reg_src`, `alu_control`, `flag_w` and `pcs` are combinational from `op`/`funct`/`rd` and the current state.

State actions and transitions:
- FETCH:
  - Drives `adr_src`=0, `alu_src_a`=1, `alu_src_b`=10, ADD, `result_src`=10.
  - `ir_write` = `next_pc` = `mem_ready`.
  - Stays while `mem_ready`=0; goes to DECODE when 1.
- DECODE: `alu_src_a`=1, `alu_src_b`=10, ADD, `result_src`=10. Next state by `op`:
  - `op`=00, `funct`[5]=0 -> EXECR; `funct`[5]=1 -> EXECI.
  - `op`=01 -> MEMADR.
  - `op`=10 -> BRANCH.
  - `op`=11 or illegal DP code -> TRAP.
- MEMADR: `alu_src_a`=0, `alu_src_b`=01, ADD. Goes to MEMRD if `funct`[0]=1, else MEMWR.
- MEMRD: `adr_src`=1, `result_src`=00. Holds until `mem_ready`, then MEMWB.
- MEMWB: `result_src`=01, `reg_w`=1, `instr_done`=1. Goes to FETCH.
- MEMWR:
  - `adr_src`=1, `result_src`=00.
  - `mem_w`=1 every cycle in the state; memory commits on the cycle `mem_ready`=1.
  - Holds until `mem_ready`, then FETCH with `instr_done`=1 that cycle.
- EXECR / EXECI:
  - `alu_src_a`=0; `alu_src_b`=00 (EXECR) or 01 (EXECI).
  - ALU decode active; `flag_w` asserted here only.
  - Goes to ALUWB, except CMP/TST, which go to FETCH with `instr_done`=1.
- ALUWB: `result_src`=00, `reg_w`=1, `instr_done`=1. Goes to FETCH.
- BRANCH: `alu_src_a`=0, `alu_src_b`=01, ADD, `result_src`=10, `branch`=1, `instr_done`=1. Goes to FETCH.
- TRAP: `illegal`=1 for one cycle, `reg_w` = `mem_w` = 0. Goes to FETCH; the instruction is dropped.

ALU decode (`funct`[4:1]), zero-extended to ALU_CTRL_W:
- Codes: 0100 ADD=000, 0010 SUB=001, 0000 AND=010, 1100 ORR=011, 0001 EOR=100, 1010 CMP=001, 1000 TST=010.
- Any other code is illegal.

Flags:
- `flag_w`[1] = `funct`[0] in EXEC states.
- `flag_w`[0] = `funct`[0] & (ADD|SUB|CMP) in EXEC states.
- CMP/TST force `flag_w`[1]=1 regardless of `funct`[0].
- `flag_w` is 00 in all other states.

Boundary conditions:
- `mem_ready` held low indefinitely leaves the FSM parked; there is no timeout.
- Instruction inputs may change outside DECODE/EXEC/MEMADR without effect.
- Async reset mid-MEMWR deasserts `mem_w` immediately, in the same cycle.

Test Plan:
1. Reset asserted mid-MEMRD, then released, `mem_ready`=1 -> state=0, `ir_write`=1 in the first cycle.
2. ADD R1,R2,#5 (`op`=00, `funct`=101000), `mem_ready`=1 -> states 0,1,7,8,0; `alu_control`=000 in EXECI; `reg_w`=1 only in ALUWB; `flag_w`=00.
3. LDR (`funct`=011001) with `mem_ready` low 3 cycles in MEMRD -> 0,1,2,3,3,3,3,4,0; `result_src`=01 and `reg_w`=1 in MEMWB.
4. STR (`funct`=011000), `mem_ready` low 2 cycles -> `mem_w`=1 for 3 cycles in MEMWR, then FETCH; `reg_w` never 1.
5. CMP (`funct`=010101) with EXT_OPS=1 -> EXECR, `flag_w`=11, `alu_control`=001, directly to FETCH. With EXT_OPS=0 -> TRAP, `illegal` pulse.
6. ADDS PC,... (`rd`=15, `funct`=001001) -> `pcs`=1 in ALUWB. B (`op`=10) -> BRANCH with `branch`=1, `pcs`=1, `imm_src`=10.
